// File: rtl/led_scan_ctrl.sv
// Time-multiplexed hex digit scanner with a frame-synchronous double buffer,
// inter-digit blanking and optional leading-zero suppression.
module led_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned PRESCALE     = 1000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic                    lz_en,
   output logic [3:0]              hex_out,
   output logic [NUM_DIGITS-1:0]   digit_en_n,
   output logic                    load_ack,
   output logic                    frame_done
);

   localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [0:0]              state_q, state_d;
   logic [4*NUM_DIGITS-1:0] active_q, active_d;
   logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
   logic                    pend_vld_q, pend_vld_d;

   logic                    cnt_wrap;
   logic                    frame_last;
   logic                    swap;

   logic [NUM_DIGITS-1:0]   sup;
   logic                    zero_above;
   logic [3:0]              hex_d;
   logic [NUM_DIGITS-1:0]   en_d;
   logic                    frame_done_d;
   logic                    load_ack_d;

   // Scan counters
   always_comb begin
      cnt_wrap   = (cnt_q == CNT_LAST);
      frame_last = cnt_wrap && (idx_q == IDX_LAST);
      cnt_d      = cnt_wrap ? '0 : cnt_q + 1'b1;
      idx_d      = idx_q;
      if (cnt_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
         ST_SHOW:  if (cnt_wrap)            state_d = ST_BLANK;
         default:                           state_d = ST_BLANK;
      endcase
   end

   // Swap consumes the pending value held before this edge; a same-cycle load
   // lands in pending and waits for the next frame end.
   always_comb begin
      swap       = frame_last && pend_vld_q;
      active_d   = swap ? pend_q : active_q;
      pend_d     = load ? digits_in : pend_q;
      pend_vld_d = load | (pend_vld_q & ~swap);
   end

   // Outputs are registered from next state so they line up with the counter
   // value of the cycle in which they are visible.
   always_comb begin
      zero_above = 1'b1;
      sup        = '0;
      for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
         zero_above = zero_above & (active_d[4*i +: 4] == 4'h0);
         sup[i]     = lz_en & zero_above;
      end

      hex_d = active_d[{idx_d, 2'b00} +: 4];
      en_d  = '1;
      if ((state_d == ST_SHOW) && !sup[idx_d]) begin
         en_d[idx_d] = 1'b0;
      end

      frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
      load_ack_d   = frame_done_d && pend_vld_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         idx_q      <= '0;
         state_q    <= ST_BLANK;
         active_q   <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         hex_out    <= 4'h0;
         digit_en_n <= '1;
         load_ack   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         state_q    <= state_d;
         active_q   <= active_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         hex_out    <= hex_d;
         digit_en_n <= en_d;
         load_ack   <= load_ack_d;
         frame_done <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Randomized and directed bench for led_scan_ctrl against a cycle-index based
// reference model (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2).
module tb_led_scan_ctrl;

   localparam int ND = 4;
   localparam int PS = 8;
   localparam int BC = 2;
   localparam int FL = ND * PS;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] digits_in = 16'h0;
   logic        lz_en = 1'b0;
   logic [3:0]  hex_out;
   logic [3:0]  digit_en_n;
   logic        load_ack;
   logic        frame_done;

   led_scan_ctrl #(
      .NUM_DIGITS  (ND),
      .PRESCALE    (PS),
      .BLANK_CYCLES(BC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .digits_in (digits_in),
      .lz_en     (lz_en),
      .hex_out   (hex_out),
      .digit_en_n(digit_en_n),
      .load_ack  (load_ack),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference model: t counts cycles since the last reset edge.
   int          t = 0;
   logic [15:0] m_act = 16'h0;
   logic [15:0] m_pend = 16'h0;
   bit          m_pv = 1'b0;
   bit          m_lz = 1'b0;

   logic [9:0] obs;
   logic [9:0] exp;
   assign obs = {digit_en_n, hex_out, load_ack, frame_done};

   function automatic logic [9:0] model_out();
      int          slot = t % PS;
      int          dig = (t / PS) % ND;
      logic [15:0] upper = m_act >> (4 * dig);
      logic [3:0]  en = 4'hF;
      logic [3:0]  hex = upper[3:0];
      bit          fd = ((t % FL) == FL - 1);
      bit          ack = fd && m_pv;
      bit          suppressed = m_lz && (dig != 0) && (upper == 16'h0);
      if (slot >= BC && !suppressed) en[dig] = 1'b0;
      return {en, hex, ack, fd};
   endfunction

   // Drive one cycle of inputs, advance past the edge, update the model.
   task automatic tick(input bit rst, input bit ld, input logic [15:0] din, input bit lz);
      reset     = rst;
      load      = ld;
      digits_in = din;
      lz_en     = lz;
      @(posedge clk);
      #1;
      if (rst) begin
         t = 0; m_act = 16'h0; m_pend = 16'h0; m_pv = 1'b0;
      end else begin
         if (((t % FL) == FL - 1) && m_pv) begin
            m_act = m_pend;
            m_pv  = 1'b0;
         end
         if (ld) begin
            m_pend = din;
            m_pv   = 1'b1;
         end
         t++;
      end
      m_lz = lz;
   endtask

   task automatic do_reset(input bit lz);
      tick(1'b1, 1'b0, 16'h0, lz);
      tick(1'b1, 1'b0, 16'h0, lz);
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      checks++;
      if (obs !== 10'b1111_0000_0_0) begin
         failures++;
         $display("FAIL reset_values got=%b want=%b", obs, 10'b1111_0000_0_0);
      end
      for (int c = 0; c < 40; c++) begin
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL reset_scan c=%0d got=%b want=%b", c, obs, exp);
         end
         if (c == 2 || c == 8 || c == 10 || c == 31) begin
            checks++;
            if ((c == 2 && digit_en_n !== 4'b1110) || (c == 8 && digit_en_n !== 4'b1111) ||
                (c == 10 && digit_en_n !== 4'b1101) || (c == 31 && frame_done !== 1'b1)) begin
               failures++;
               $display("FAIL reset_plan c=%0d got en=%b fd=%b", c, digit_en_n, frame_done);
            end
         end
         tick(1'b0, 1'b0, 16'h0, 1'b0);
      end
   endtask

   task automatic test_load_swap();
      do_reset(1'b0);
      for (int c = 0; c < 66; c++) begin
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL load_swap c=%0d got=%b want=%b", c, obs, exp);
         end
         if (c == 31 || c == 34 || c == 58) begin
            checks++;
            if ((c == 31 && {load_ack, frame_done} !== 2'b11) ||
                (c == 34 && {digit_en_n, hex_out} !== {4'b1110, 4'h4}) ||
                (c == 58 && {digit_en_n, hex_out} !== {4'b0111, 4'h1})) begin
               failures++;
               $display("FAIL load_swap_plan c=%0d got en=%b hex=%h ack=%b fd=%b",
                        c, digit_en_n, hex_out, load_ack, frame_done);
            end
         end
         tick(1'b0, c == 5, 16'h1234, 1'b0);
      end
   endtask

   task automatic test_lz();
      do_reset(1'b1);
      for (int c = 0; c < 100; c++) begin
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL lz c=%0d got=%b want=%b", c, obs, exp);
         end
         if (c == 34 || c == 42 || c == 50 || c == 58 || c == 66 || c == 74) begin
            checks++;
            if ((c == 34 && {digit_en_n, hex_out} !== {4'b1110, 4'h0}) ||
                (c == 42 && {digit_en_n, hex_out} !== {4'b1101, 4'h5}) ||
                (c == 50 && digit_en_n !== 4'b1111) || (c == 58 && digit_en_n !== 4'b1111) ||
                (c == 66 && {digit_en_n, hex_out} !== {4'b1110, 4'h0}) ||
                (c == 74 && digit_en_n !== 4'b1111)) begin
               failures++;
               $display("FAIL lz_plan c=%0d got en=%b hex=%h", c, digit_en_n, hex_out);
            end
         end
         tick(1'b0, c == 5 || c == 40, (c == 5) ? 16'h0050 : 16'h0000, 1'b1);
      end
   endtask

   task automatic test_back_to_back();
      int acks = 0;
      do_reset(1'b0);
      for (int c = 0; c < 64; c++) begin
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL back_to_back c=%0d got=%b want=%b", c, obs, exp);
         end
         if (load_ack === 1'b1) acks++;
         if (c == 34) begin
            checks++;
            if (hex_out !== 4'h2) begin
               failures++;
               $display("FAIL back_to_back_last_wins got=%h want=2", hex_out);
            end
         end
         tick(1'b0, c == 3 || c == 10, (c == 3) ? 16'h1111 : 16'h2222, 1'b0);
      end
      checks++;
      if (acks != 1) begin
         failures++;
         $display("FAIL back_to_back_acks got=%0d want=1", acks);
      end
   endtask

   task automatic test_swap_cycle_load();
      do_reset(1'b0);
      for (int c = 0; c < 100; c++) begin
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL swap_cycle_load c=%0d got=%b want=%b", c, obs, exp);
         end
         if (c == 31 || c == 63 || c == 34 || c == 66) begin
            checks++;
            if (((c == 31 || c == 63) && load_ack !== 1'b1) ||
                (c == 34 && hex_out !== 4'hA) || (c == 66 && hex_out !== 4'h5)) begin
               failures++;
               $display("FAIL swap_cycle_plan c=%0d got hex=%h ack=%b", c, hex_out, load_ack);
            end
         end
         tick(1'b0, c == 5 || c == 31, (c == 5) ? 16'hAAAA : 16'h5555, 1'b0);
      end
   endtask

   task automatic test_reset_mid();
      int acks = 0;
      do_reset(1'b0);
      for (int c = 0; c < 60; c++) begin
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL reset_mid c=%0d got=%b want=%b", c, obs, exp);
         end
         if (load_ack === 1'b1) acks++;
         if (c == 21 || c == 23) begin
            checks++;
            if ((c == 21 && obs !== 10'b1111_0000_0_0) ||
                (c == 23 && {digit_en_n, hex_out} !== {4'b1110, 4'h0})) begin
               failures++;
               $display("FAIL reset_mid_plan c=%0d got=%b", c, obs);
            end
         end
         tick(c == 20, c == 5, 16'h9876, 1'b0);
      end
      checks++;
      if (acks != 0) begin
         failures++;
         $display("FAIL reset_mid_acks got=%0d want=0", acks);
      end
   endtask

   task automatic test_random();
      bit          lz = 1'b0;
      logic [15:0] din;
      do_reset(lz);
      for (int c = 0; c < 1500; c++) begin
         exp = model_out();
         checks++;
         if (obs !== exp) begin
            failures++;
            $display("FAIL random c=%0d t=%0d got=%b want=%b", c, t, obs, exp);
         end
         for (int n = 0; n < 4; n++) begin
            din[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         end
         // lz only changes into a blanking slot so its sampling cycle is invisible.
         if ((t % PS) == PS - 1 && $urandom_range(0, 3) == 0) lz = ~lz;
         tick($urandom_range(0, 399) == 0, $urandom_range(0, 11) == 0, din, lz);
      end
   endtask

   initial begin
      test_reset();
      test_load_swap();
      test_lz();
      test_back_to_back();
      test_swap_cycle_load();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
